csa: RTL and testbench

- 16-bit carry-select adder with registered outputs; computes {cout,sum} = A + B + cin.
- Operand is split into 4-bit blocks. Block 0 is a ripple-carry adder fed by cin.
- Each upper block has two ripple-carry adders, one precomputed with carry-in 0 and one with carry-in 1. A 2:1 mux selects between them using the previous block's carry-out.
- General-purpose arithmetic leaf used in datapaths needing faster-than-ripple addition with one cycle of latency.

---
 rtl/csa.sv | 76 +++++++
 tb/tb_csa.sv | 131 +++++++++++++
 2 files changed

// File: rtl/csa.sv
// Carry-select adder with one registered output stage: {cout,sum} = A + B + cin.
// Block 0 ripples from cin; each upper block precomputes both carry-in cases and muxes.
module csa #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NBLK = WIDTH / BLOCK;

   // carry[i] is the resolved carry into block i; carry[NBLK] is the final carry-out
   logic [NBLK:0]      carry;
   logic [WIDTH-1:0]   sum_next;
   logic [WIDTH-1:0]   sum_reg;
   logic               cout_reg;

   assign carry[0] = cin;

   generate
      for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
         if (gi == 0) begin : g_ripple
            logic [BLOCK:0]   c_chain;
            logic [BLOCK-1:0] s_bits;

            assign c_chain[0] = carry[0];
            for (genvar gj = 0; gj < BLOCK; gj++) begin : g_fa
               logic a_bit, b_bit;
               assign a_bit          = A[gi*BLOCK + gj];
               assign b_bit          = B[gi*BLOCK + gj];
               assign s_bits[gj]     = a_bit ^ b_bit ^ c_chain[gj];
               assign c_chain[gj+1]  = (a_bit & b_bit) | (c_chain[gj] & (a_bit ^ b_bit));
            end
            assign sum_next[gi*BLOCK +: BLOCK] = s_bits;
            assign carry[gi+1]                 = c_chain[BLOCK];
         end else begin : g_select
            logic [BLOCK:0]   c0_chain, c1_chain;
            logic [BLOCK-1:0] s0_bits, s1_bits;

            assign c0_chain[0] = 1'b0;
            assign c1_chain[0] = 1'b1;
            for (genvar gj = 0; gj < BLOCK; gj++) begin : g_fa
               logic a_bit, b_bit;
               assign a_bit          = A[gi*BLOCK + gj];
               assign b_bit          = B[gi*BLOCK + gj];
               assign s0_bits[gj]    = a_bit ^ b_bit ^ c0_chain[gj];
               assign c0_chain[gj+1] = (a_bit & b_bit) | (c0_chain[gj] & (a_bit ^ b_bit));
               assign s1_bits[gj]    = a_bit ^ b_bit ^ c1_chain[gj];
               assign c1_chain[gj+1] = (a_bit & b_bit) | (c1_chain[gj] & (a_bit ^ b_bit));
            end
            assign sum_next[gi*BLOCK +: BLOCK] = carry[gi] ? s1_bits : s0_bits;
            assign carry[gi+1]                 = carry[gi] ? c1_chain[BLOCK] : c0_chain[BLOCK];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_reg  <= '0;
         cout_reg <= 1'b0;
      end else begin
         sum_reg  <= sum_next;
         cout_reg <= carry[NBLK];
      end
   end

   assign sum  = sum_reg;
   assign cout = cout_reg;

endmodule

// File: tb/tb_csa.sv
// Self-checking bench for csa: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed literal results.
module tb_csa;

   logic        clk;
   logic        rst;
   logic [15:0] A;
   logic [15:0] B;
   logic        cin;
   logic [15:0] sum;
   logic        cout;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state: result expected on the outputs after the last edge
   logic [16:0] exp_total;
   logic        model_valid = 1'b0;

   csa #(.WIDTH(16), .BLOCK(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .A    (A),
      .B    (B),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) begin
         exp_total   = 17'd0;
         model_valid = 1'b1;
      end else begin
         exp_total = {1'b0, A} + {1'b0, B} + {16'd0, cin};
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         n_checks++;
         if ({cout, sum} !== exp_total)
            $display("FAIL model: got cout=%0b sum=%h, need cout=%0b sum=%h",
                     cout, sum, exp_total[16], exp_total[15:0]);
         if ({cout, sum} !== exp_total) n_fail++;
      end
   end

   // drive at negedge, advance across one rising edge, return at next negedge
   task automatic step(input logic [15:0] a, input logic [15:0] b, input logic c, input logic r);
      A   = a;
      B   = b;
      cin = c;
      rst = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_lit(input string name, input logic [15:0] es, input logic ec);
      n_checks++;
      if (sum !== es || cout !== ec) begin
         n_fail++;
         $display("FAIL %s: got cout=%0b sum=%h, need cout=%0b sum=%h", name, cout, sum, ec, es);
      end
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      logic [15:0] s;
      logic        co;
      string       name;
   } vec_t;

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{16'hF00F, 16'h0FF0, 1'b0, 16'hFFFF, 1'b0, "v_f00f"};
      vecs[1]  = '{16'hF0FF, 16'hF00F, 1'b0, 16'hE10E, 1'b1, "v_f0ff"};
      vecs[2]  = '{16'h08FF, 16'h080F, 1'b0, 16'h110E, 1'b0, "v_08ff"};
      vecs[3]  = '{16'h0809, 16'h080D, 1'b0, 16'h1016, 1'b0, "v_0809"};
      vecs[4]  = '{16'h4949, 16'h494D, 1'b0, 16'h9296, 1'b0, "v_4949"};
      vecs[5]  = '{16'h0909, 16'h494D, 1'b0, 16'h5256, 1'b0, "v_0909"};
      vecs[6]  = '{16'h294B, 16'h494D, 1'b0, 16'h7298, 1'b0, "v_294b"};
      vecs[7]  = '{16'h6D59, 16'h4949, 1'b0, 16'hB6A2, 1'b0, "v_6d59"};
      vecs[8]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "chain_full"};
      vecs[9]  = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, "chain_b0b1"};
      vecs[10] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, "chain_b2b3"};

      A = 16'hFFFF; B = 16'hFFFF; cin = 1'b1; rst = 1'b1;
      @(negedge clk);
      step(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      step(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      check_lit("reset", 16'h0000, 1'b0);
      step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      check_lit("post_reset", 16'hFFFF, 1'b1);

      foreach (vecs[i]) begin
         step(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0);
         check_lit(vecs[i].name, vecs[i].s, vecs[i].co);
      end

      step(16'h0000, 16'h0000, 1'b1, 1'b0);
      check_lit("cin_only", 16'h0001, 1'b0);

      for (int k = 0; k < 6; k++) begin
         if (k[0]) begin
            step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
            check_lit("alt_ones", 16'hFFFF, 1'b1);
         end else begin
            step(16'h0000, 16'h0000, 1'b0, 1'b0);
            check_lit("alt_zero", 16'h0000, 1'b0);
         end
      end
      step(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      check_lit("mid_reset", 16'h0000, 1'b0);
      step(16'h1234, 16'h4321, 1'b1, 1'b0);
      check_lit("after_mid_reset", 16'h5556, 1'b0);

      for (int k = 0; k < 10000; k++)
         step(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
